// File: rtl/gate_lab_pkg.sv
// Shared types and gate evaluation helpers for the debounced logic-gate lab.
package gate_lab_pkg;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5
  } gate_mode_t;

  localparam logic [2:0] MODE_COUNT = 3'd6;

  // Advance to the next mode, wrapping after the last one.
  function automatic gate_mode_t mode_next(input gate_mode_t m);
    gate_mode_t w_n;
    if (3'(m) == (MODE_COUNT - 3'd1)) begin
      w_n = MODE_AND;
    end else begin
      w_n = gate_mode_t'(3'(m) + 3'd1);
    end
    return w_n;
  endfunction

  // Direct reduction of the operands; bits outside mask are neutral.
  function automatic logic gate_direct(input gate_mode_t m, input logic [7:0] a,
                                       input logic [7:0] mask);
    logic w_and;
    logic w_or;
    logic w_xor;
    logic w_res;
    w_and = &(a | ~mask);
    w_or  = |(a & mask);
    w_xor = ^(a & mask);
    case (m)
      MODE_AND:  w_res = w_and;
      MODE_OR:   w_res = w_or;
      MODE_XOR:  w_res = w_xor;
      MODE_NAND: w_res = ~w_and;
      MODE_NOR:  w_res = ~w_or;
      MODE_XNOR: w_res = ~w_xor;
      default:   w_res = 1'b0;
    endcase
    return w_res;
  endfunction

  // De Morgan dual form: AND/OR built from the complemented operands.
  function automatic logic gate_dual(input gate_mode_t m, input logic [7:0] a,
                                     input logic [7:0] mask);
    logic [7:0] w_na;
    logic       w_and;
    logic       w_or;
    logic       w_par;
    logic       w_res;
    w_na  = ~a;
    w_and = ~|(w_na & mask);
    w_or  = ~&(w_na | ~mask);
    w_par = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_par = w_par ^ (a[i] & mask[i]);
    end
    case (m)
      MODE_AND:  w_res = w_and;
      MODE_OR:   w_res = w_or;
      MODE_XOR:  w_res = w_par;
      MODE_NAND: w_res = ~w_and;
      MODE_NOR:  w_res = ~w_or;
      MODE_XNOR: w_res = ~w_par;
      default:   w_res = 1'b0;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key: 2-flop synchronizer followed by a stable-time debouncer.
module key_debouncer
  import gate_lab_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_key_db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_state;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous key into the clock domain; idle level is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= 1'b1;
      r_cnt   <= '0;
    end else if (r_sync2 == r_state) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_state <= ~r_state;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_key_db = r_state;

endmodule

// File: rtl/gate_lab_debounced.sv
// Debounced logic-gate lab: N operand keys, one mode key, direct and dual results.
module gate_lab_debounced
  import gate_lab_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] in_keys,
  input  logic              in_mode_key,
  output logic [N_KEYS-1:0] out_keys,
  output logic              out_result,
  output logic              out_result_dm,
  output logic [2:0]        out_mode,
  output logic              out_mismatch,
  output logic              vcc_for_keys
);

  localparam logic [7:0] KEY_MASK = 8'((16'd1 << N_KEYS) - 16'd1);

  logic [N_KEYS-1:0] w_keys_db;
  logic              w_mode_db;
  logic [7:0]        w_a;
  logic              w_press;
  gate_mode_t        w_mode_nxt;
  gate_mode_t        r_mode;
  logic              r_mode_db_d;
  logic              r_result_n;
  logic              r_result_dm_n;
  logic              r_mismatch_n;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_key    (in_keys[g]),
      .o_key_db (w_keys_db[g])
    );
  end

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_key    (in_mode_key),
    .o_key_db (w_mode_db)
  );

  // Logical operands (pressed = 1) padded to the helper width.
  always_comb begin
    w_a = 8'd0;
    w_a[N_KEYS-1:0] = ~w_keys_db;
  end

  // A debounced press is the 1->0 edge of the mode key; the next mode is used
  // for the result in the same cycle so mode and operands update together.
  always_comb begin
    w_press = r_mode_db_d & ~w_mode_db;
    if (w_press) begin
      w_mode_nxt = mode_next(r_mode);
    end else begin
      w_mode_nxt = r_mode;
    end
  end

  // Mode register, edge history and registered active-low results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= MODE_AND;
      r_mode_db_d   <= 1'b1;
      r_result_n    <= 1'b1;
      r_result_dm_n <= 1'b1;
    end else begin
      r_mode        <= w_mode_nxt;
      r_mode_db_d   <= w_mode_db;
      r_result_n    <= ~gate_direct(w_mode_nxt, w_a, KEY_MASK);
      r_result_dm_n <= ~gate_dual(w_mode_nxt, w_a, KEY_MASK);
    end
  end

  // Sticky self-check: any disagreement between the two forms latches the LED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch_n <= 1'b1;
    end else if (r_result_n != r_result_dm_n) begin
      r_mismatch_n <= 1'b0;
    end else begin
      r_mismatch_n <= r_mismatch_n;
    end
  end

  assign out_keys      = w_keys_db;
  assign out_result    = r_result_n;
  assign out_result_dm = r_result_dm_n;
  assign out_mode      = ~3'(r_mode);
  assign out_mismatch  = r_mismatch_n;
  assign vcc_for_keys  = 1'b1;

endmodule

// File: tb/tb_gate_lab_debounced.sv
// Randomized and directed bench for gate_lab_debounced (N_KEYS=3, DEBOUNCE_CYCLES=4).
module tb_gate_lab_debounced;

  localparam int NK = 3;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] in_keys;
  logic          in_mode_key;
  logic [NK-1:0] out_keys;
  logic          out_result;
  logic          out_result_dm;
  logic [2:0]    out_mode;
  logic          out_mismatch;
  logic          vcc_for_keys;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: pin pipeline, debounced levels, samples since last settle.
  bit [3:0] m_d1, m_d2, m_db;
  bit       m_hist[4][$];
  bit       m_dbm_d;
  int       m_mode;
  bit       m_res;

  logic [2:0] exp_modes [6];

  always #5 clk = ~clk;

  gate_lab_debounced #(.N_KEYS(NK), .DEBOUNCE_CYCLES(DB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_keys       (in_keys),
    .in_mode_key   (in_mode_key),
    .out_keys      (out_keys),
    .out_result    (out_result),
    .out_result_dm (out_result_dm),
    .out_mode      (out_mode),
    .out_mismatch  (out_mismatch),
    .vcc_for_keys  (vcc_for_keys)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Gate truth from the number of pressed keys.
  function automatic bit ref_gate(input int mode, input bit [2:0] pressed);
    int c;
    c = $countones(pressed);
    case (mode)
      0: return c == NK;
      1: return c > 0;
      2: return (c % 2) == 1;
      3: return c != NK;
      4: return c == 0;
      5: return (c % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_d1 = 4'hF; m_d2 = 4'hF; m_db = 4'hF;
    for (int k = 0; k < 4; k++) m_hist[k].delete();
    m_dbm_d = 1'b1;
    m_mode  = 0;
    m_res   = 1'b1;
  endtask

  // One rising edge of the reference model.
  task automatic model_edge();
    bit [3:0] pins;
    bit [3:0] smp;
    pins = {in_mode_key, in_keys};
    if (m_dbm_d && !m_db[3]) m_mode = (m_mode + 1) % 6;
    m_res   = !ref_gate(m_mode, ~m_db[2:0]);
    m_dbm_d = m_db[3];
    smp  = m_d2;
    m_d2 = m_d1;
    m_d1 = pins;
    for (int k = 0; k < 4; k++) begin
      if (smp[k] == m_db[k]) begin
        m_hist[k].delete();
      end else begin
        m_hist[k].push_back(smp[k]);
        if (m_hist[k].size() == DB) begin
          m_db[k] = ~m_db[k];
          m_hist[k].delete();
        end
      end
    end
  endtask

  task automatic compare_model();
    check("keys",      {5'd0, out_keys}, {5'd0, m_db[2:0]});
    check("result",    {7'd0, out_result}, {7'd0, m_res});
    check("result_dm", {7'd0, out_result_dm}, {7'd0, m_res});
    check("mode",      {5'd0, out_mode}, {5'd0, ~3'(m_mode)});
    check("mismatch",  {7'd0, out_mismatch}, 8'd1);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_keys"}, {5'd0, out_keys}, 8'h07);
    check({tag, "_res"}, {7'd0, out_result}, 8'd1);
    check({tag, "_resdm"}, {7'd0, out_result_dm}, 8'd1);
    check({tag, "_mode"}, {5'd0, out_mode}, 8'h07);
    check({tag, "_mism"}, {7'd0, out_mismatch}, 8'd1);
    check({tag, "_vcc"}, {7'd0, vcc_for_keys}, 8'd1);
  endtask

  // Assert reset between edges, check, release well away from the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("rst_mid");
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_modes[0] = 3'b110; exp_modes[1] = 3'b101; exp_modes[2] = 3'b100;
    exp_modes[3] = 3'b011; exp_modes[4] = 3'b010; exp_modes[5] = 3'b111;

    rst_n = 1'b0;
    in_keys = 3'b111;
    in_mode_key = 1'b1;
    model_reset();
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Clean press of all keys in AND mode: latency 6, result one cycle later.
    step(2);
    in_keys = 3'b000;
    step(5);
    check("and_keys_early", {5'd0, out_keys}, 8'h07);
    step(1);
    check("and_keys_lat", {5'd0, out_keys}, 8'h00);
    check("and_res_pre", {7'd0, out_result}, 8'd1);
    step(1);
    check("and_res_on", {7'd0, out_result}, 8'd0);
    in_keys = 3'b010;
    step(7);
    check("and_res_off", {7'd0, out_result}, 8'd1);

    // Three-cycle glitch on key 0 is ignored.
    in_keys = 3'b111;
    step(10);
    in_keys = 3'b110;
    step(3);
    in_keys = 3'b111;
    step(10);
    check("glitch_keys", {5'd0, out_keys}, 8'h07);
    check("glitch_res", {7'd0, out_result}, 8'd1);

    // Every mode against every operand combination, then one mode press.
    for (int mi = 0; mi < 6; mi++) begin
      for (int c = 0; c < 8; c++) begin
        in_keys = ~3'(c);
        step(8);
      end
      in_mode_key = 1'b0;
      step(20);
      in_mode_key = 1'b1;
      step(20);
      check("mode_step", {5'd0, out_mode}, {5'd0, exp_modes[mi]});
    end

    // Mode press and key 2 press settle on the same edge.
    in_keys = 3'b111;
    step(10);
    in_keys = 3'b011;
    in_mode_key = 1'b0;
    step(6);
    check("simul_mode_pre", {5'd0, out_mode}, 8'h07);
    step(1);
    check("simul_mode", {5'd0, out_mode}, 8'h06);
    check("simul_res", {7'd0, out_result}, 8'd0);
    check("simul_keys", {5'd0, out_keys}, 8'h03);
    in_mode_key = 1'b1;
    in_keys = 3'b111;
    step(10);

    // Randomized pin activity including short glitches.
    for (int it = 0; it < 300; it++) begin
      in_keys = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) in_mode_key = ~in_mode_key;
      step($urandom_range(1, 8));
    end
    in_keys = 3'b111;
    in_mode_key = 1'b1;
    step(10);

    // Reset mid-debounce discards the partial count.
    do_reset();
    step(4);
    in_keys = 3'b110;
    step(4);
    in_keys = 3'b111;
    do_reset();
    step(10);
    check("rst_partial", {7'd0, out_keys[0]}, 8'd1);

    // Key held through reset release: full debounce, no mode change.
    in_keys = 3'b110;
    do_reset();
    step(5);
    check("rst_held_early", {7'd0, out_keys[0]}, 8'd1);
    step(1);
    check("rst_held_lat", {7'd0, out_keys[0]}, 8'd0);
    step(3);
    check("rst_held_mode", {5'd0, out_mode}, 8'h07);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_lab_debounced.md
GATE_LAB_DEBOUNCED -- requirements
Module: gate_lab_debounced

Interface
REQ-001 Parameter N_KEYS, default 2, range 2..8: number of operand keys.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, minimum 2: required stable-input duration in clk cycles.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_keys  input  N_KEYS  operand keys, asynchronous, active-low (0 = pressed).
REQ-006 in_mode_key  input  1  mode-select key, asynchronous, active-low.
REQ-007 out_keys  output  N_KEYS  debounced operand keys echoed to LEDs, active-low.
REQ-008 out_result  output  1  gate result, direct form, active-low LED (0 = lit = logical 1).
REQ-009 out_result_dm  output  1  gate result computed via De Morgan dual form, active-low LED.
REQ-010 out_mode  output  3  current mode index, active-low LEDs.
REQ-011 out_mismatch  output  1  sticky self-check error LED, active-low.
REQ-012 vcc_for_keys  output  1  constant 1, key pull-up supply.

Function
REQ-013 Each key input SHALL pass a 2-flop synchronizer before any other logic.
REQ-014 Each key SHALL hold a debounced state and a counter; counter clears when synchronized input equals debounced state, else increments.
REQ-015 Debounced state SHALL toggle, and counter clear, when counter reaches DEBOUNCE_CYCLES-1 with input still differing; pulses shorter than DEBOUNCE_CYCLES cycles SHALL be ignored.
REQ-016 Pin-to-debounced latency SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean edge.
REQ-017 Logical operand a[i] SHALL be the inverse of debounced key i (pressed = 1).
REQ-018 Modes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, reduced across all N_KEYS operands.
REQ-019 Mode SHALL increment by one on each debounced mode-key press (debounced 1->0 edge), wrapping 5->0; holding the key SHALL give one increment; release SHALL have no effect.
REQ-020 Direct result: reduction of a[] per mode; dual result: AND as ~|(~a), OR as ~&(~a), XOR/XNOR via parity of a, inverted modes as inverse of their dual.
REQ-021 All outputs except vcc_for_keys SHALL be registered; result reflects debounced keys and mode one cycle after they change.
REQ-022 Simultaneous mode increment and operand change in one cycle: next output cycle SHALL use new mode and new operands together.
REQ-023 out_mismatch SHALL go 0 the cycle after registered direct and dual results differ and stay 0 until reset.
REQ-024 out_mode SHALL equal bitwise inverse of mode index.

Reset
REQ-025 rst_n low SHALL immediately clear: synchronizer flops and debounced states to 1 (released), counters 0, mode 0 (AND).
REQ-026 Reset output values: out_keys all 1, out_result 1, out_result_dm 1, out_mode 3'b111, out_mismatch 1.
REQ-027 Reset asserted mid-debounce SHALL discard partial counts; no mode increment SHALL occur on reset release with key held (debounced state starts released, first press counted only after full debounce).

Structure
REQ-028 Package gate_lab_pkg SHALL hold gate_mode_t enum (6 modes, 3 bits), MODE_COUNT constant, and the direct/dual reduction functions.
REQ-029 Sub-module key_debouncer (synchronizer + counter + debounced state, parameter DEBOUNCE_CYCLES) SHALL be instantiated N_KEYS+1 times.

Verification (DEBOUNCE_CYCLES=4, N_KEYS=3)
REQ-030 Reset, all keys released -> out_result=1, out_result_dm=1, out_mode=111, out_mismatch=1, out_keys=111.
REQ-031 Mode AND, press all 3 keys cleanly -> out_keys=000 after 6 cycles, out_result=0 one cycle later; release key 1 -> out_result=1.
REQ-032 Key 0 glitch low for 3 cycles -> out_keys[0] stays 1, outputs unchanged.
REQ-033 Six clean mode presses with holds of 20 cycles -> out_mode steps 110,101,100,011,010, then wraps to 111; out_mismatch stays 1 throughout all 8 operand combinations in every mode.
REQ-034 Mode key press and key 2 press debounced in same cycle -> next output uses OR with new operand.
REQ-035 Assert rst_n at counter value 2 during key press -> after release, debounced state remains 1; press held through reset release -> debounced low after 6 cycles, no mode change without mode key.
